// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, ID-resolved branch/jump redirect,
// sticky halt and run-time statistics counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               beq_i,
  input  logic               bne_i,
  input  logic               bgez_i,
  input  logic               jmp_i,
  input  logic               jr_i,
  input  logic               jal_i,
  input  logic               halt_req_i,
  input  logic [31:0]        rs_data_i,
  input  logic [31:0]        rt_data_i,
  input  logic [31:0]        imem_rdata_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        if_id_instr_o,
  output logic [31:0]        if_id_pc4_o,
  output logic               if_id_valid_o,
  output logic               redirect_o,
  output logic               halted_o,
  output logic [31:0]        cycle_cnt_o,
  output logic [31:0]        jump_cnt_o,
  output logic [31:0]        btaken_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] jump_q, jump_d;
  logic [31:0] btaken_q, btaken_d;

  logic        hon;
  logic        cond;
  logic        jump_req;
  logic [31:0] imm;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic [31:0] pc_plus4;

  assign hon      = valid_q & ~stall_i & ~halted_q;
  assign cond     = (beq_i  & (rs_data_i == rt_data_i)) |
                    (bne_i  & (rs_data_i != rt_data_i)) |
                    (bgez_i & ~rs_data_i[31]);
  // The decoder raises jmp alongside jal; OR-ing keeps a lone jal honoured too.
  assign jump_req = jmp_i | jal_i;
  assign imm      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign btgt     = pc4_q + imm;
  assign jtgt     = jr_i ? {rs_data_i[31:2], 2'b00}
                         : {pc4_q[31:28], instr_q[25:0], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  assign redirect_o = hon & ~halt_req_i & (jump_req | cond);

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cycle_d  = cycle_q;
    jump_d   = jump_q;
    btaken_d = btaken_q;
    if (!halted_q) begin
      cycle_d = cycle_q + 32'd1;
      if (hon && halt_req_i) begin
        halted_d = 1'b1;
        instr_d  = 32'd0;
        valid_d  = 1'b0;
      end else if (stall_i) begin
        pc_d = pc_q;
      end else if (hon && jump_req) begin
        pc_d    = jtgt;
        instr_d = 32'd0;
        valid_d = 1'b0;
        jump_d  = jump_q + 32'd1;
      end else if (hon && cond) begin
        pc_d     = btgt;
        instr_d  = 32'd0;
        valid_d  = 1'b0;
        btaken_d = btaken_q + 32'd1;
      end else begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata_i;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cycle_q  <= 32'd0;
      jump_q   <= 32'd0;
      btaken_q <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cycle_q  <= cycle_d;
      jump_q   <= jump_d;
      btaken_q <= btaken_d;
    end
  end

  assign imem_addr_o   = pc_q[IMEM_AW+1:2];
  assign pc_o          = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign cycle_cnt_o   = cycle_q;
  assign jump_cnt_o    = jump_q;
  assign btaken_cnt_o  = btaken_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. Holds the PC, drives the word-addressed instruction ROM, and latches the fetched word and PC+4 for the decode stage. It also consumes the branch and jump strobes that the instruction decoder produces for the instruction currently in IF/ID, resolves them in ID, and redirects the PC. Run-time statistics counters for the display board live here as well.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_AW, 10, instruction ROM word-address width
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  from hazard unit; freeze the PC and IF/ID, and ignore ID branch strobes this cycle
- beq, bne, bgez, jmp, jr, jal  in  1 each  decoder strobes for the instruction in IF/ID
- halt_req  in  1  from ID: SYSCALL with $v0 == 10
- rs_data, rt_data  in  32 each  forwarded ID operands
- imem_rdata  in  32  combinational ROM data for imem_addr
- imem_addr  out  IMEM_AW  pc[IMEM_AW+1:2]
- pc  out  32  current fetch PC
- if_id_instr  out  32  latched instruction (0 = NOP)
- if_id_pc4  out  32  latched PC+4; also the JAL link value, since there is no delay slot
- if_id_valid  out  1  IF/ID holds a real instruction
- redirect  out  1  pulses high in the cycle an ID branch or jump is honoured
- halted  out  1  sticky halt flag
- cycle_cnt, jump_cnt, btaken_cnt  out  32 each  statistics counters

## Operation
- Definitions:
  - hon = if_id_valid & ~stall & ~halted
  - imm = sign-extended if_id_instr[15:0], shifted left by 2
  - btgt = if_id_pc4 + imm
  - jtgt = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}
- Conditional branch taken (cond):
  - beq: rs_data == rt_data
  - bne: rs_data != rt_data
  - bgez: rs_data[31] == 0
- Jump target: jr takes {rs_data[31:2], 2'b00} and has priority over jtgt. The decoder asserts jmp together with both jr and jal.
- Per-edge priority, highest first:
  1. rst: load the reset state.
  2. halted: hold everything.
  3. hon & halt_req: set halted. Load a NOP into IF/ID (instr 0, valid 0). PC holds.
  4. stall: PC and IF/ID hold.
  5. hon & jmp: PC <= jump target. IF/ID <= NOP. jump_cnt++. redirect = 1.
  6. hon & cond: PC <= btgt. IF/ID <= NOP. btaken_cnt++. redirect = 1.
  7. Otherwise sequential: PC <= pc + 4. if_id_instr <= imem_rdata. if_id_pc4 <= pc + 4. if_id_valid <= 1.
- Branch not taken: behaves as sequential, with no counter change.
- Arithmetic: all adds are 32-bit modulo with no overflow trap. Counters wrap 32'hFFFF_FFFF -> 0.
- cycle_cnt increments every edge while halted = 0 and rst = 0, including stalled cycles.
- redirect is combinational from the current IF/ID contents and inputs.
- A halt_req and a branch strobe are never asserted together. If they are, halt wins.
- Only rst leaves the halted state.

## Timing
- Reset values:
  - pc = RESET_PC
  - if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0
  - halted = 0
  - all counters = 0
  - redirect = 0, because valid = 0
- Fetch latency: the word at PC is visible on if_id_instr one edge after PC is presented.
- Taken branch or jump resolved in cycle n:
  - pc = target at n+1, with one bubble in IF/ID.
  - The target instruction is in IF/ID at n+2.
- Stall is level-sensitive with no internal memory. A branch held under stall is honoured on the first cycle stall drops.
- rst asserted mid-stall, mid-redirect or while halted: the next edge gives the reset state unconditionally.

## Test plan
- Reset, then free-run with ROM[i] = i+1: pc steps 0, 4, 8, and so on. if_id_instr = 1, 2, 3 on consecutive edges. cycle_cnt tracks edges.
- beq with rs = rt = 5 and imm = 3 at pc4 = 0x10: redirect = 1, next pc = 0x1C, one NOP bubble, btaken_cnt = 1. Repeat with rt = 6: sequential, no count.
- bgez with rs = 0x8000_0000: not taken. With rs = 0: taken. bne with 1 vs 2: taken.
- jr with rs = 0x0000_0043: pc = 0x40, jump_cnt = 1. jal with index 0x40 and pc4 = 0x1000_0008: pc = 0x1000_0100.
- beq taken held under stall for 3 cycles: pc, IF/ID and counters frozen, redirect = 0. On the cycle stall drops, the redirect fires.
- halt_req: halted = 1 and frozen for 10 cycles, cycle_cnt frozen. rst then returns pc = RESET_PC and all counters to 0.
